// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the 8x32 register bank.
// Widths are fixed here so every module in the slice agrees on them.
package reg_file_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Replace the bytes of old_w selected by be with the matching bytes of new_w.
  function automatic word_t be_merge(input word_t old_w, input word_t new_w,
                                     input logic [BE_W-1:0] be);
    word_t res;
    res = old_w;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/word_sel_8to1.sv
// 8:1 word selector used for each read port of the register bank.
module word_sel_8to1
  import reg_file_pkg::*;
(
  input  logic [ADDR_W-1:0]             sel,
  input  logic [DEPTH-1:0][DATA_W-1:0]  words,
  output logic [DATA_W-1:0]             word_c
);

  // Pick one word of the bank; the address range covers every entry.
  always_comb begin
    word_c = '0;
    case (sel)
      3'd0:    word_c = words[0];
      3'd1:    word_c = words[1];
      3'd2:    word_c = words[2];
      3'd3:    word_c = words[3];
      3'd4:    word_c = words[4];
      3'd5:    word_c = words[5];
      3'd6:    word_c = words[6];
      3'd7:    word_c = words[7];
      default: word_c = '0;
    endcase
  end

endmodule

// File: rtl/write_decoder_3to8.sv
// One-hot write strobe generator: at most one entry strobe is high, and only when we=1.
module write_decoder_3to8
  import reg_file_pkg::*;
(
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic [DEPTH-1:0]  wr_stb_c
);

  // Decode the write address into a per-entry strobe.
  always_comb begin
    wr_stb_c = '0;
    if (we) wr_stb_c[wr_addr] = 1'b1;
  end

endmodule

// File: rtl/register_file_8x32.sv
// 8-entry x 32-bit register bank: one byte-enabled write port, two combinational
// read ports, synchronous clear, and a per-entry "written" scoreboard (wr_mask).
// Optional macro RF_WR_BYPASS_EN: forward the in-flight write to a read port
// addressing the same entry in the same cycle. Undefined: reads see registered
// state only.
module register_file_8x32
  import reg_file_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr0,
  output logic [DATA_W-1:0] rd_data0,
  output logic              rd_vld0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_vld1,
  output logic [DEPTH-1:0]  wr_mask
);

  logic [DEPTH-1:0]             wr_stb_c;
  logic [DEPTH-1:0][DATA_W-1:0] bank_q;
  logic [DATA_W-1:0]            sel0_c;
  logic [DATA_W-1:0]            sel1_c;

  write_decoder_3to8 u_wr_dec (
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_stb_c (wr_stb_c)
  );

  // Bank and scoreboard update: reset and clr both wipe everything and drop any write.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      bank_q  <= '0;
      wr_mask <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (wr_stb_c[i]) begin
          bank_q[i]  <= be_merge(bank_q[i], wr_data, wr_be);
          wr_mask[i] <= 1'b1;
        end
      end
    end
  end

  word_sel_8to1 u_sel0 (
    .sel    (rd_addr0),
    .words  (bank_q),
    .word_c (sel0_c)
  );

  word_sel_8to1 u_sel1 (
    .sel    (rd_addr1),
    .words  (bank_q),
    .word_c (sel1_c)
  );

`ifdef RF_WR_BYPASS_EN
  logic wr_live_c;
  assign wr_live_c = we & ~clr & ~reset;

  // Read ports with same-cycle forwarding of an accepted write to a matching address.
  always_comb begin
    rd_data0 = sel0_c;
    rd_vld0  = wr_mask[rd_addr0];
    rd_data1 = sel1_c;
    rd_vld1  = wr_mask[rd_addr1];
    if (wr_live_c && (rd_addr0 == wr_addr)) begin
      rd_data0 = be_merge(sel0_c, wr_data, wr_be);
      rd_vld0  = 1'b1;
    end
    if (wr_live_c && (rd_addr1 == wr_addr)) begin
      rd_data1 = be_merge(sel1_c, wr_data, wr_be);
      rd_vld1  = 1'b1;
    end
  end
`else
  // Read ports reflect registered state only; a concurrent write is not visible.
  always_comb begin
    rd_data0 = sel0_c;
    rd_vld0  = wr_mask[rd_addr0];
    rd_data1 = sel1_c;
    rd_vld1  = wr_mask[rd_addr1];
  end
`endif

endmodule

// File: tb/tb_register_file_8x32.sv
// Randomized self-checking bench for register_file_8x32 against an array model.
// Honours RF_WR_BYPASS_EN in the same way as the design.
module tb_register_file_8x32;

  logic        clk;
  logic        reset;
  logic        clr;
  logic        we;
  logic [2:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic [2:0]  rd_addr0;
  logic [31:0] rd_data0;
  logic        rd_vld0;
  logic [2:0]  rd_addr1;
  logic [31:0] rd_data1;
  logic        rd_vld1;
  logic [7:0]  wr_mask;

  logic [31:0] mem_m [8];
  logic        written_m [8];

  int n_tests;
  int n_fail;

  register_file_8x32 dut (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_be    (wr_be),
    .wr_data  (wr_data),
    .rd_addr0 (rd_addr0),
    .rd_data0 (rd_data0),
    .rd_vld0  (rd_vld0),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd_data1),
    .rd_vld1  (rd_vld1),
    .wr_mask  (wr_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Expected read data: stored word, plus same-cycle forwarding when enabled.
  function automatic logic [31:0] exp_data(input logic [2:0] a);
    logic [31:0] r;
    r = mem_m[a];
`ifdef RF_WR_BYPASS_EN
    if (we && !clr && !reset && a == wr_addr)
      for (int b = 0; b < 4; b++) if (wr_be[b]) r[8*b +: 8] = wr_data[8*b +: 8];
`endif
    return r;
  endfunction

  function automatic logic exp_vld(input logic [2:0] a);
    logic v;
    v = written_m[a];
`ifdef RF_WR_BYPASS_EN
    if (we && !clr && !reset && a == wr_addr) v = 1'b1;
`endif
    return v;
  endfunction

  function automatic logic [7:0] exp_mask();
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = written_m[i];
    return m;
  endfunction

  task automatic check_ports(input string tag);
    chk({tag, "_d0"}, rd_data0, exp_data(rd_addr0));
    chk({tag, "_v0"}, 32'(rd_vld0), 32'(exp_vld(rd_addr0)));
    chk({tag, "_d1"}, rd_data1, exp_data(rd_addr1));
    chk({tag, "_v1"}, 32'(rd_vld1), 32'(exp_vld(rd_addr1)));
    chk({tag, "_mask"}, 32'(wr_mask), 32'(exp_mask()));
  endtask

  // Advance one clock, applying the architectural rules to the model.
  task automatic tick();
    @(posedge clk);
    if (reset || clr) begin
      for (int i = 0; i < 8; i++) begin
        mem_m[i] = 32'h0;
        written_m[i] = 1'b0;
      end
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) mem_m[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
      written_m[wr_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; clr = 1'b0; we = 1'b0;
    wr_addr = 3'd0; wr_be = 4'h0; wr_data = 32'h0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    idle_inputs();
    we = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    idle_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 8; i++) begin
      mem_m[i] = $urandom();
      written_m[i] = 1'b1;
    end
    idle_inputs();
    rd_addr0 = 3'd0;
    rd_addr1 = 3'd0;

    // Dirty the bank before reset so the reset check means something.
    @(posedge clk); #1;
    we = 1'b1; wr_addr = 3'd2; wr_be = 4'hF; wr_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // 1: everything reads zero / unwritten after reset.
    for (int a = 0; a < 8; a++) begin
      rd_addr0 = 3'(a);
      rd_addr1 = 3'(7 - a);
      #1;
      chk("rst_d0", rd_data0, 32'h0);
      chk("rst_v0", 32'(rd_vld0), 32'h0);
      chk("rst_d1", rd_data1, 32'h0);
      chk("rst_v1", 32'(rd_vld1), 32'h0);
    end
    chk("rst_mask", 32'(wr_mask), 32'h0);

    // 2: full-word write.
    do_write(3'd3, 32'hDEADBEEF, 4'hF);
    rd_addr0 = 3'd3; #1;
    chk("wr3_data", rd_data0, 32'hDEADBEEF);
    chk("wr3_vld", 32'(rd_vld0), 32'h1);
    chk("wr3_mask", 32'(wr_mask), 32'h08);

    // 3: byte-enable partial write.
    do_write(3'd3, 32'h11223344, 4'b0101);
    #1;
    chk("be_merge", rd_data0, 32'hDE22BE44);

    // 4: read-during-write on port 1.
    idle_inputs();
    we = 1'b1; wr_addr = 3'd5; wr_data = 32'hA5A5A5A5; wr_be = 4'hF;
    rd_addr1 = 3'd5; #1;
`ifdef RF_WR_BYPASS_EN
    chk("rdw_same_d", rd_data1, 32'hA5A5A5A5);
    chk("rdw_same_v", 32'(rd_vld1), 32'h1);
`else
    chk("rdw_same_d", rd_data1, 32'h0);
    chk("rdw_same_v", 32'(rd_vld1), 32'h0);
`endif
    tick();
    idle_inputs(); #1;
    chk("rdw_next_d", rd_data1, 32'hA5A5A5A5);
    chk("rdw_next_v", 32'(rd_vld1), 32'h1);

    // be=0 write still marks the entry as written, data holds.
    do_write(3'd6, 32'hFFFFFFFF, 4'h0);
    rd_addr0 = 3'd6; #1;
    chk("be0_data", rd_data0, 32'h0);
    chk("be0_vld", 32'(rd_vld0), 32'h1);
    chk("be0_mask", 32'(wr_mask), 32'h68);

    // 5: clr wins over a same-cycle write.
    idle_inputs();
    clr = 1'b1; we = 1'b1; wr_addr = 3'd1; wr_data = 32'h12345678; wr_be = 4'hF;
    tick();
    idle_inputs(); #1;
    chk("clr_mask", 32'(wr_mask), 32'h0);
    for (int a = 0; a < 8; a++) begin
      rd_addr0 = 3'(a); #1;
      chk("clr_d", rd_data0, 32'h0);
      chk("clr_v", 32'(rd_vld0), 32'h0);
    end

    // 6: fill with addr*0x01010101 and read random pairs.
    for (int a = 0; a < 8; a++) do_write(3'(a), 32'(a) * 32'h01010101, 4'hF);
    chk("fill_mask", 32'(wr_mask), 32'hFF);
    for (int k = 0; k < 24; k++) begin
      rd_addr0 = 3'($urandom_range(0, 7));
      rd_addr1 = (k % 3 == 0) ? rd_addr0 : 3'($urandom_range(0, 7));
      #1;
      chk("fill_d0", rd_data0, 32'(rd_addr0) * 32'h01010101);
      chk("fill_d1", rd_data1, 32'(rd_addr1) * 32'h01010101);
      if (rd_addr0 == rd_addr1) chk("fill_same", rd_data0, rd_data1);
    end

    // Randomized traffic including rare clr/reset, checked every cycle.
    for (int k = 0; k < 400; k++) begin
      reset    = ($urandom_range(0, 49) == 0);
      clr      = ($urandom_range(0, 29) == 0);
      we       = ($urandom_range(0, 3) != 0);
      wr_addr  = 3'($urandom_range(0, 7));
      wr_be    = 4'($urandom_range(0, 15));
      wr_data  = $urandom();
      rd_addr0 = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
      rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
      #2;
      check_ports("rnd");
      tick();
    end
    idle_inputs(); #1;
    check_ports("end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
